muldiv_sequencer: RTL and testbench

- Multi-cycle HI/LO unit beside the single-cycle ALU in the MIPS datapath. Services MULTU, DIVU, MTHI and MTLO.
- Iterates a shared shift/add-subtract datapath for WIDTH cycles per operation.
- Exposes busy/done so the pipeline control stalls MFHI/MFLO and new mul/div issue until results are valid.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit: MULTU, DIVU, MTHI and MTLO for the MIPS datapath.
// MULTU is shift-add and DIVU is restoring division. Each runs for WIDTH
// cycles, then spends one FINISH cycle pulsing done.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL    = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product accumulator
    logic [2*WIDTH-1:0] mcand_q, mcand_d;  // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvs_q, dvs_d;

    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic               last;

    // One iteration of the shift-add and restoring-divide datapaths
    always_comb begin
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        div_shift = {rem_q, dvd_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        div_diff  = div_shift - {1'b0, dvs_q};
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {dvd_q[WIDTH-2:0], div_ge};
        last      = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state logic for the sequencer and the HI/LO registers
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            mcand_d  = {{WIDTH{1'b0}}, inputA};
                            mplier_d = inputB;
                            acc_d    = '0;
                            cnt_d    = '0;
                            dbz_d    = 1'b0;
                            state_d  = MUL;
                        end
                        OP_DIVU: begin
                            if (inputB == '0) begin
                                // No iterations; report through the FINISH pulse.
                                dbz_d   = 1'b1;
                                state_d = FINISH;
                            end else begin
                                dvd_d   = inputA;
                                dvs_d   = inputB;
                                rem_d   = '0;
                                cnt_d   = '0;
                                dbz_d   = 1'b0;
                                state_d = DIV;
                            end
                        end
                        OP_MTHI: hi_d = inputA;
                        OP_MTLO: lo_d = inputA;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (last) begin
                    hi_d    = mul_sum[2*WIDTH-1:WIDTH];
                    lo_d    = mul_sum[WIDTH-1:0];
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
                rem_d = div_rem;
                dvd_d = div_quo;
                if (last) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that abandons any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
        end
    end

    // Status and result outputs
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        divByZero = dbz_q;
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: one task per scenario, inline checks.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Present one request for a single edge; returns 1ns after that edge.
    // Operands are scrambled afterwards so late changes would be visible.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        inputA = a;
        inputB = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        inputA = $urandom;
        inputB = $urandom;
    endtask

    // Count edges until done is seen; cyc=0 means the bound expired.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            tests++;
            fails++;
            $display("FAIL wait_done: no done pulse within 100 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        inputA = '0;
        inputB = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (divByZero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b want 0", divByZero); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 7 x 6 with a cycle-by-cycle busy/done profile
    task automatic test_multu_basic();
        issue(2'b00, 32'd7, 32'd6);
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (done !== (i == 32)) begin
                fails++; $display("FAIL mul_done_c%0d: got %b want %b", i, done, (i == 32));
            end
            tests++;
            if (busy !== (i <= 32)) begin
                fails++; $display("FAIL mul_busy_c%0d: got %b want %b", i, busy, (i <= 32));
            end
            if (i == 16) begin
                tests++; if (lo !== 32'h0) begin fails++; $display("FAIL mul_lo_mid: got %h want 0", lo); end
            end
            if (i == 32) begin
                tests++; if (hi !== 32'h0) begin fails++; $display("FAIL mul_hi: got %h want 0", hi); end
                tests++; if (lo !== 32'h2a) begin fails++; $display("FAIL mul_lo: got %h want 2a", lo); end
                tests++; if (divByZero !== 1'b0) begin fails++; $display("FAIL mul_dbz: got %b want 0", divByZero); end
            end
        end
    endtask

    task automatic test_multu_max();
        int c;
        issue(2'b00, 32'hffff_ffff, 32'hffff_ffff);
        wait_done(c);
        tests++; if (c != 32) begin fails++; $display("FAIL mulmax_lat: got %0d want 32", c); end
        tests++; if (hi !== 32'hffff_fffe) begin fails++; $display("FAIL mulmax_hi: got %h want fffffffe", hi); end
        tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL mulmax_lo: got %h want 00000001", lo); end
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mulmax_idle: got %b want 0", busy); end
    endtask

    task automatic test_divu();
        logic [W-1:0] a_v [3] = '{32'd100, 32'd5, 32'hffff_ffff};
        logic [W-1:0] b_v [3] = '{32'd7, 32'd9, 32'd1};
        logic [W-1:0] q_v [3] = '{32'd14, 32'd0, 32'hffff_ffff};
        logic [W-1:0] r_v [3] = '{32'd2, 32'd5, 32'd0};
        int c;
        for (int k = 0; k < 3; k++) begin
            issue(2'b01, a_v[k], b_v[k]);
            wait_done(c);
            tests++; if (c != 32) begin fails++; $display("FAIL div%0d_lat: got %0d want 32", k, c); end
            tests++; if (lo !== q_v[k]) begin fails++; $display("FAIL div%0d_quo: got %h want %h", k, lo, q_v[k]); end
            tests++; if (hi !== r_v[k]) begin fails++; $display("FAIL div%0d_rem: got %h want %h", k, hi, r_v[k]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero();
        int c;
        issue(2'b10, 32'h1234, 32'h0);
        tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi: got %h want 1234", hi); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mthi_done: got %b want 0", done); end
        issue(2'b11, 32'h5678, 32'h0);
        tests++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo: got %h want 5678", lo); end
        issue(2'b01, 32'd9, 32'd0);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL dz_done: got %b want 1", done); end
        tests++; if (divByZero !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b want 1", divByZero); end
        tests++; if (hi !== 32'h1234) begin fails++; $display("FAIL dz_hi: got %h want 1234", hi); end
        tests++; if (lo !== 32'h5678) begin fails++; $display("FAIL dz_lo: got %h want 5678", lo); end
        @(posedge clk);
        #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL dz_pulse: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL dz_idle: got %b want 0", busy); end
        tests++; if (divByZero !== 1'b1) begin fails++; $display("FAIL dz_sticky: got %b want 1", divByZero); end
        issue(2'b00, 32'd2, 32'd3);
        tests++; if (divByZero !== 1'b0) begin fails++; $display("FAIL dz_clear: got %b want 0", divByZero); end
        wait_done(c);
        tests++; if (lo !== 32'd6) begin fails++; $display("FAIL dz_mul_lo: got %h want 6", lo); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL dz_mul_hi: got %h want 0", hi); end
        @(posedge clk);
        #1;
    endtask

    // Requests issued while busy (MUL and FINISH) must be dropped
    task automatic test_back_to_back();
        int ndone = 0;
        int at = 0;
        issue(2'b00, 32'd3, 32'd4);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; op = 2'b10; inputA = 32'hdead;
            end else if (i == 10) begin
                start = 1'b1; op = 2'b01; inputA = 32'd100; inputB = 32'd7;
            end else if (i == 33) begin
                start = 1'b1; op = 2'b11; inputA = 32'hbeef;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                at = i;
            end
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL b2b_count: got %0d want 1", ndone); end
        tests++; if (at != 32) begin fails++; $display("FAIL b2b_when: got %0d want 32", at); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL b2b_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'd12) begin fails++; $display("FAIL b2b_lo: got %h want c", lo); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int c;
        issue(2'b10, 32'h77, 32'h0);
        tests++; if (hi !== 32'h77) begin fails++; $display("FAIL rm_pre_hi: got %h want 77", hi); end
        issue(2'b00, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rm_done: got %b want 0", done); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rm_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rm_lo: got %h want 0", lo); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        tests++; if (ndone != 0) begin fails++; $display("FAIL rm_no_done: got %0d want 0", ndone); end
        issue(2'b00, 32'd2, 32'd2);
        wait_done(c);
        tests++; if (c != 32) begin fails++; $display("FAIL rm_lat: got %0d want 32", c); end
        tests++; if (lo !== 32'd4) begin fails++; $display("FAIL rm_lo_after: got %h want 4", lo); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_multu_basic();
        test_multu_max();
        test_divu();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
